// File: rtl/nnspc_pkg.sv
// nnspc_pkg: shared definitions for the NNFET serial configuration port.
//   - default field widths for the selector, current-DAC and reserve fields
//   - FSM state encoding
//   - width helper for the frame bit counter
package nnspc_pkg;

    localparam int NSEL_W_DEF    = 5;
    localparam int DAC_W_DEF     = 4;
    localparam int RE_W_DEF      = 1;
    localparam int PARITY_EN_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_READY = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // Counter must hold 0..FRAME_W+1 (FRAME_W+1 marks an overrun).
    function automatic int cnt_width(input int frame_w);
        return $clog2(frame_w + 2);
    endfunction

endpackage

// File: rtl/nnspc_shadow_if.sv
// nnspc_shadow_if: serial config bus of one port instance.
//   cfg_in/cfg_en/strobe : serial data, shift enable, commit request (master -> slave)
//   nsel/dac/re          : committed shadow fields (slave -> master)
//   cfg_out              : daisy-chain output (slave -> master)
//   cfg_ok/cfg_err       : one-cycle commit status pulses (slave -> master)
interface nnspc_shadow_if
    import nnspc_pkg::*;
#(
    parameter int NSEL_W = NSEL_W_DEF,
    parameter int DAC_W  = DAC_W_DEF,
    parameter int RE_W   = RE_W_DEF
);
    logic              cfg_in;
    logic              cfg_en;
    logic              strobe;
    logic [NSEL_W-1:0] nsel;
    logic [DAC_W-1:0]  dac;
    logic [RE_W-1:0]   re;
    logic              cfg_out;
    logic              cfg_ok;
    logic              cfg_err;

    modport master (
        output cfg_in, cfg_en, strobe,
        input  nsel, dac, re, cfg_out, cfg_ok, cfg_err
    );

    modport slave (
        input  cfg_in, cfg_en, strobe,
        output nsel, dac, re, cfg_out, cfg_ok, cfg_err
    );
endinterface

// File: rtl/nnspc_shift.sv
// nnspc_shift: LSB-first frame shift register, saturating bit counter and
// parity of the captured frame.
//   clk, resetn  : clock, async active-low reset
//   shift_en     : shift din in at the MSB end this cycle
//   clr          : clear the bit counter (shift register is kept)
//   din          : serial data
//   cfg_data     : data portion of the frame (sr[CFG_W-1:0])
//   sr_lsb       : sr[0], used as the daisy-chain output
//   parity_odd   : XOR over all FRAME_W frame bits
//   cnt_next     : counter value that will be loaded on the next edge
module nnspc_shift #(
    parameter int CFG_W   = 10,
    parameter int FRAME_W = 11,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             din,
    output logic [CFG_W-1:0] cfg_data,
    output logic             sr_lsb,
    output logic             parity_odd,
    output logic [CNT_W-1:0] cnt_next
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FRAME_W + 1);

    logic [FRAME_W-1:0] sr;
    logic [CNT_W-1:0]   cnt;

    always_comb begin
        cnt_next = cnt;
        if (clr) begin
            cnt_next = '0;
        end else if (shift_en && (cnt != CNT_SAT)) begin
            cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
            if (shift_en) begin
                sr <= {din, sr[FRAME_W-1:1]};
            end
        end
    end

    assign cfg_data   = sr[CFG_W-1:0];
    assign sr_lsb     = sr[0];
    assign parity_odd = ^sr;

endmodule

// File: rtl/nnspc_shadow.sv
// nnspc_shadow: serial configuration port with a shadow register.
// Frames are shifted in LSB-first and only reach nsel/dac/re when a strobe
// arrives with exactly FRAME_W bits captured and even parity.
//   clk, resetn : clock, async active-low reset
//   bus         : nnspc_shadow_if slave port (serial in, shadow fields, status)
//
// state    | meaning
// ST_IDLE  | no bits captured since the last strobe/reset
// ST_SHIFT | partial frame captured
// ST_READY | exactly FRAME_W bits captured, commit possible
// ST_OVER  | more than FRAME_W bits captured, commit will be rejected
module nnspc_shadow
    import nnspc_pkg::*;
#(
    parameter int NSEL_W    = NSEL_W_DEF,
    parameter int DAC_W     = DAC_W_DEF,
    parameter int RE_W      = RE_W_DEF,
    parameter int PARITY_EN = PARITY_EN_DEF
) (
    input logic           clk,
    input logic           resetn,
    nnspc_shadow_if.slave bus
);

    localparam int CFG_W   = NSEL_W + DAC_W + RE_W;
    localparam int FRAME_W = CFG_W + PARITY_EN;
    localparam int CNT_W   = cnt_width(FRAME_W);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);

    logic             shift_en;
    logic [CFG_W-1:0] cfg_data;
    logic             sr_lsb;
    logic             parity_odd;
    logic [CNT_W-1:0] cnt_next;
    logic             parity_ok;

    state_t            state;
    logic [NSEL_W-1:0] nsel_q;
    logic [DAC_W-1:0]  dac_q;
    logic [RE_W-1:0]   re_q;
    logic              ok_q;
    logic              err_q;

    // Strobe wins over shifting: the bit presented with a strobe is dropped.
    assign shift_en  = bus.cfg_en & ~bus.strobe;
    assign parity_ok = (PARITY_EN == 0) || !parity_odd;

    nnspc_shift #(
        .CFG_W   (CFG_W),
        .FRAME_W (FRAME_W),
        .CNT_W   (CNT_W)
    ) u_shift (
        .clk        (clk),
        .resetn     (resetn),
        .shift_en   (shift_en),
        .clr        (bus.strobe),
        .din        (bus.cfg_in),
        .cfg_data   (cfg_data),
        .sr_lsb     (sr_lsb),
        .parity_odd (parity_odd),
        .cnt_next   (cnt_next)
    );

    function automatic state_t state_of(input logic [CNT_W-1:0] c);
        if (c == '0)       return ST_IDLE;
        if (c < FRAME_CNT) return ST_SHIFT;
        if (c == FRAME_CNT) return ST_READY;
        return ST_OVER;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            nsel_q <= '0;
            dac_q  <= '0;
            re_q   <= '0;
            ok_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ok_q  <= 1'b0;
            err_q <= 1'b0;
            if (bus.strobe) begin
                state <= ST_IDLE;
                if ((state == ST_READY) && parity_ok) begin
                    re_q   <= cfg_data[RE_W-1:0];
                    dac_q  <= cfg_data[RE_W+DAC_W-1:RE_W];
                    nsel_q <= cfg_data[CFG_W-1:RE_W+DAC_W];
                    ok_q   <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end else begin
                // Track the counter value being loaded so a strobe on the
                // cycle right after the last shift sees the right state.
                state <= state_of(cnt_next);
            end
        end
    end

    assign bus.nsel    = nsel_q;
    assign bus.dac     = dac_q;
    assign bus.re      = re_q;
    assign bus.cfg_out = sr_lsb;
    assign bus.cfg_ok  = ok_q;
    assign bus.cfg_err = err_q;

endmodule
